// File: rtl/sar_sampler.sv
// sar_sampler: periodic SAR ADC requester with 2^LogAvg sample averaging.
// Ports: clk_i, rst_ni (sync, active-low), en_i, clr_ovr_i, adc_eoc_i,
//   adc_result_i | adc_start_o, avg_o, valid_o, busy_o, overrun_o.
module sar_sampler #(
  parameter int Width        = 10,
  parameter int PeriodCycles = 1000,
  parameter int LogAvg       = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_ovr_i,
  input  logic             adc_eoc_i,
  input  logic [Width-1:0] adc_result_i,
  output logic             adc_start_o,
  output logic [Width-1:0] avg_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam int TW = $clog2(PeriodCycles);
  localparam int CW = (LogAvg > 0) ? LogAvg : 1;
  localparam int AW = Width + LogAvg;

  localparam logic [TW-1:0] TMax = TW'(PeriodCycles - 1);
  localparam logic [CW-1:0] CMax = CW'((1 << LogAvg) - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [CW-1:0] cnt;
  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic          tick;
  logic          last;
  logic          ovr_set;

  assign tick    = en_i && (timer == TMax);
  assign sum     = acc + AW'(adc_result_i);
  assign last    = (cnt == CMax);
  assign busy_o  = (state != IDLE);

  // A tick that cannot launch a conversion is dropped and flagged,
  // including the tick landing on the capture cycle itself.
  assign ovr_set = tick && ((state != IDLE) || !adc_eoc_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      timer       <= '0;
      cnt         <= '0;
      acc         <= '0;
      adc_start_o <= 1'b0;
      avg_o       <= '0;
      valid_o     <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      adc_start_o <= 1'b0;
      valid_o     <= 1'b0;

      if (!en_i || timer == TMax) begin
        timer <= '0;
      end else begin
        timer <= timer + TW'(1);
      end

      if (ovr_set) begin
        overrun_o <= 1'b1;
      end else if (clr_ovr_i) begin
        overrun_o <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          // Disabling discards any partial average.
          if (!en_i) begin
            acc <= '0;
            cnt <= '0;
          end
          if (tick && adc_eoc_i) begin
            state       <= START;
            adc_start_o <= 1'b1;
          end
        end
        START: begin
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!adc_eoc_i) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (adc_eoc_i) begin
            state <= IDLE;
            if (last) begin
              avg_o   <= Width'(sum >> LogAvg);
              valid_o <= 1'b1;
              acc     <= '0;
              cnt     <= '0;
            end else begin
              acc <= sum;
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_sampler.sv
// tb_sar_sampler: directed checks of sar_sampler with behavioural ADCs.
// dut0: LogAvg=0, dut2: LogAvg=2, both PeriodCycles=20.
module tb_sar_sampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int t = 0;

  logic       rst0, en0, clr0, eoc0, start0, valid0, busy0, ovr0;
  logic [9:0] res0, avg0;
  logic       rst2, en2, clr2, eoc2, start2, valid2, busy2, ovr2;
  logic [9:0] res2, avg2;

  sar_sampler #(.Width(10), .PeriodCycles(20), .LogAvg(0)) dut0 (
    .clk_i(clk), .rst_ni(rst0), .en_i(en0), .clr_ovr_i(clr0),
    .adc_eoc_i(eoc0), .adc_result_i(res0), .adc_start_o(start0),
    .avg_o(avg0), .valid_o(valid0), .busy_o(busy0), .overrun_o(ovr0)
  );

  sar_sampler #(.Width(10), .PeriodCycles(20), .LogAvg(2)) dut2 (
    .clk_i(clk), .rst_ni(rst2), .en_i(en2), .clr_ovr_i(clr2),
    .adc_eoc_i(eoc2), .adc_result_i(res2), .adc_start_o(start2),
    .avg_o(avg2), .valid_o(valid2), .busy_o(busy2), .overrun_o(ovr2)
  );

  // Behavioural converters: eoc drops the cycle after start is seen,
  // stays low for lat cycles, then rises with the result.
  int         lat0 = 5, cnt0 = 0, lat2 = 5, cnt2 = 0;
  logic       meoc0 = 1'b1, meoc2 = 1'b1;
  logic       hold0 = 1'b0, hold2 = 1'b0;
  logic [9:0] nxt0 = '0, mres0 = '0, nxt2 = '0, mres2 = '0;

  always @(posedge clk) begin
    if (start0 === 1'b1) begin
      meoc0 <= 1'b0;
      cnt0  <= lat0;
    end else if (cnt0 != 0) begin
      cnt0 <= cnt0 - 1;
      if (cnt0 == 1) begin
        meoc0 <= 1'b1;
        mres0 <= nxt0;
      end
    end
  end

  always @(posedge clk) begin
    if (start2 === 1'b1) begin
      meoc2 <= 1'b0;
      cnt2  <= lat2;
    end else if (cnt2 != 0) begin
      cnt2 <= cnt2 - 1;
      if (cnt2 == 1) begin
        meoc2 <= 1'b1;
        mres2 <= nxt2;
      end
    end
  end

  assign eoc0 = meoc0 && !hold0;
  assign res0 = mres0;
  assign eoc2 = meoc2 && !hold2;
  assign res2 = mres2;

  int nst0 = 0, nst2 = 0, nval2 = 0;
  always @(posedge clk) begin
    if (start0 === 1'b1) nst0 <= nst0 + 1;
    if (start2 === 1'b1) nst2 <= nst2 + 1;
    if (valid2 === 1'b1) nval2 <= nval2 + 1;
  end

  task run_to(input int n);
    while (t < n) begin
      @(negedge clk);
      t++;
    end
  endtask

  task reset_all();
    en0 = 1'b0; en2 = 1'b0;
    clr0 = 1'b0; clr2 = 1'b0;
    hold0 = 1'b0; hold2 = 1'b0;
    repeat (40) @(negedge clk);
    rst0 = 1'b0; rst2 = 1'b0;
    repeat (3) @(negedge clk);
    rst0 = 1'b1; rst2 = 1'b1;
    t = 0;
  endtask

  task test_reset();
    int s0, s2;
    en0 = 1'b0; en2 = 1'b0; clr0 = 1'b0; clr2 = 1'b0;
    rst0 = 1'b0; rst2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({start0, valid0, busy0, ovr0} !== 4'b0 || avg0 !== 10'd0) begin
      errors++;
      $display("FAIL reset0: got s%b v%b b%b o%b avg=%h want 0",
               start0, valid0, busy0, ovr0, avg0);
    end
    checks++;
    if ({start2, valid2, busy2, ovr2} !== 4'b0 || avg2 !== 10'd0) begin
      errors++;
      $display("FAIL reset2: got s%b v%b b%b o%b avg=%h want 0",
               start2, valid2, busy2, ovr2, avg2);
    end
    rst0 = 1'b1; rst2 = 1'b1;
    s0 = nst0; s2 = nst2;
    repeat (100) @(negedge clk);
    checks++;
    if (nst0 != s0 || nst2 != s2 || busy0 !== 1'b0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: got starts %0d/%0d want 0/0",
               nst0 - s0, nst2 - s2);
    end
  endtask

  task test_single();
    reset_all();
    lat0 = 5; nxt0 = 10'h2A5; en0 = 1'b1; t = 0;
    run_to(19);
    checks++;
    if (start0 !== 1'b0) begin
      errors++; $display("FAIL early_start: got %b want 0", start0);
    end
    run_to(20);
    checks++;
    if (start0 !== 1'b1 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL first_start: got s%b b%b want 1 1", start0, busy0);
    end
    run_to(21);
    checks++;
    if (start0 !== 1'b0) begin
      errors++; $display("FAIL start_width: got %b want 0", start0);
    end
    run_to(26);
    checks++;
    if (valid0 !== 1'b0) begin
      errors++; $display("FAIL early_valid: got %b want 0", valid0);
    end
    run_to(27);
    checks++;
    if (valid0 !== 1'b1 || avg0 !== 10'h2A5) begin
      errors++;
      $display("FAIL single_avg: got v%b %h want 1 2a5", valid0, avg0);
    end
    nxt0 = 10'h15A;
    run_to(28);
    checks++;
    if (valid0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL valid_width: got v%b b%b want 0 0", valid0, busy0);
    end
    run_to(40);
    checks++;
    if (start0 !== 1'b1) begin
      errors++; $display("FAIL second_start: got %b want 1", start0);
    end
    run_to(47);
    checks++;
    if (valid0 !== 1'b1 || avg0 !== 10'h15A || ovr0 !== 1'b0) begin
      errors++;
      $display("FAIL second_avg: got v%b %h o%b want 1 15a 0",
               valid0, avg0, ovr0);
    end
  endtask

  task test_back_to_back();
    reset_all();
    lat0 = 18; nxt0 = 10'h3FF; en0 = 1'b1; t = 0;
    run_to(39);
    checks++;
    if (ovr0 !== 1'b0) begin
      errors++; $display("FAIL b2b_pre: got %b want 0", ovr0);
    end
    run_to(40);
    checks++;
    if (ovr0 !== 1'b1 || valid0 !== 1'b1 || avg0 !== 10'h3FF ||
        start0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_tick: got o%b v%b %h s%b want 1 1 3ff 0",
               ovr0, valid0, avg0, start0);
    end
    run_to(60);
    checks++;
    if (start0 !== 1'b1) begin
      errors++; $display("FAIL b2b_next: got %b want 1", start0);
    end
    reset_all();
    lat0 = 17; en0 = 1'b1; t = 0;
    run_to(40);
    checks++;
    if (start0 !== 1'b1 || ovr0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_fits: got s%b o%b want 1 0", start0, ovr0);
    end
  endtask

  task test_average();
    int vals[8] = '{100, 101, 102, 104, 1023, 1023, 1023, 1023};
    logic       ev;
    logic [9:0] ea;
    reset_all();
    lat2 = 5; en2 = 1'b1; t = 0;
    for (int i = 0; i < 8; i++) begin
      run_to(20 * (i + 1));
      nxt2 = 10'(vals[i]);
      run_to(20 * (i + 1) + 7);
      ev = (i == 3 || i == 7);
      ea = (i == 3) ? 10'd101 : 10'd1023;
      checks++;
      if (valid2 !== ev || (ev && avg2 !== ea)) begin
        errors++;
        $display("FAIL avg_cap%0d: got v%b %0d want v%b %0d",
                 i, valid2, avg2, ev, ea);
      end
    end
    run_to(168);
    checks++;
    if (valid2 !== 1'b0) begin
      errors++; $display("FAIL avg_width: got %b want 0", valid2);
    end
  endtask

  task test_overrun();
    reset_all();
    lat2 = 25; nxt2 = 10'd5; en2 = 1'b1; t = 0;
    run_to(39);
    checks++;
    if (ovr2 !== 1'b0) begin
      errors++; $display("FAIL ovr_pre: got %b want 0", ovr2);
    end
    run_to(40);
    checks++;
    if (ovr2 !== 1'b1 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set: got o%b b%b want 1 1", ovr2, busy2);
    end
    run_to(47);
    checks++;
    if (busy2 !== 1'b0 || ovr2 !== 1'b1) begin
      errors++;
      $display("FAIL ovr_done: got b%b o%b want 0 1", busy2, ovr2);
    end
    run_to(50);
    clr2 = 1'b1;
    run_to(51);
    clr2 = 1'b0;
    checks++;
    if (ovr2 !== 1'b0) begin
      errors++; $display("FAIL ovr_clear: got %b want 0", ovr2);
    end
    run_to(60);
    checks++;
    if (start2 !== 1'b1) begin
      errors++; $display("FAIL ovr_restart: got %b want 1", start2);
    end
    run_to(79);
    clr2 = 1'b1;
    run_to(80);
    clr2 = 1'b0;
    checks++;
    if (ovr2 !== 1'b1) begin
      errors++; $display("FAIL ovr_set_wins: got %b want 1", ovr2);
    end
  endtask

  task test_en_drop();
    int s, v;
    reset_all();
    lat2 = 5; nxt2 = 10'd7; en2 = 1'b1; t = 0;
    run_to(60);
    nxt2 = 10'd100;
    run_to(62);
    en2 = 1'b0;
    s = nst2; v = nval2;
    run_to(67);
    checks++;
    if (busy2 !== 1'b0 || valid2 !== 1'b0) begin
      errors++;
      $display("FAIL drop_done: got b%b v%b want 0 0", busy2, valid2);
    end
    run_to(120);
    checks++;
    if (nst2 != s || nval2 != v) begin
      errors++;
      $display("FAIL drop_quiet: got starts %0d valids %0d want 0 0",
               nst2 - s, nval2 - v);
    end
    nxt2 = 10'd8; en2 = 1'b1; t = 0;
    run_to(27);
    checks++;
    if (valid2 !== 1'b0) begin
      errors++; $display("FAIL drop_stale: got %b want 0", valid2);
    end
    run_to(87);
    checks++;
    if (valid2 !== 1'b1 || avg2 !== 10'd8) begin
      errors++;
      $display("FAIL drop_fresh: got v%b %0d want 1 8", valid2, avg2);
    end
  endtask

  task test_reset_mid();
    int s;
    reset_all();
    lat2 = 25; en2 = 1'b1; t = 0;
    run_to(30);
    checks++;
    if (busy2 !== 1'b1) begin
      errors++; $display("FAIL mid_busy: got %b want 1", busy2);
    end
    rst2 = 1'b0; hold2 = 1'b1;
    run_to(31);
    rst2 = 1'b1;
    checks++;
    if ({busy2, start2, valid2, ovr2} !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset: got b%b s%b v%b o%b want 0",
               busy2, start2, valid2, ovr2);
    end
    s = nst2;
    run_to(50);
    checks++;
    if (ovr2 !== 1'b0) begin
      errors++; $display("FAIL mid_pre: got %b want 0", ovr2);
    end
    run_to(51);
    checks++;
    if (ovr2 !== 1'b1 || start2 !== 1'b0) begin
      errors++;
      $display("FAIL mid_tick: got o%b s%b want 1 0", ovr2, start2);
    end
    run_to(55);
    hold2 = 1'b0;
    run_to(70);
    checks++;
    if (nst2 != s) begin
      errors++; $display("FAIL mid_nostart: got %0d want 0", nst2 - s);
    end
    run_to(71);
    checks++;
    if (start2 !== 1'b1) begin
      errors++; $display("FAIL mid_resync: got %b want 1", start2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_average();
    test_overrun();
    test_en_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
